counter_seq_ctrl: RTL and testbench

Command-driven controller that sequences a WIDTH-bit up-counter datapath as a programmable interval timer. It accepts load, start, stop and clear commands over a valid/ready handshake, and divides `clk` with a prescaler. It runs the counter in one-shot or periodic mode and flags terminal count. It sits between the control/register logic and the counter datapath, and is the only agent allowed to enable, clear or reconfigure that counter.

---
 rtl/counter_pkg.sv | 19 +
 rtl/counter_core.sv | 20 ++
 rtl/counter_seq_ctrl.sv | 146 ++++++++++++++
 tb/tb_counter_seq_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared encodings for the interval-timer controller: command ops, FSM states
// and the run-mode constants.
package counter_pkg;

    localparam logic [1:0] OP_LOAD  = 2'd0;
    localparam logic [1:0] OP_START = 2'd1;
    localparam logic [1:0] OP_STOP  = 2'd2;
    localparam logic [1:0] OP_CLEAR = 2'd3;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

endpackage

// File: rtl/counter_core.sv
// WIDTH-bit up-counter datapath: synchronous clear wins over enable.
module counter_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] q
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or posedge reset) begin
        if (reset)    q <= '0;
        else if (clr) q <= '0;
        else if (en)  q <= q + ONE;
    end

endmodule

// File: rtl/counter_seq_ctrl.sv
// Programmable interval timer controller: command handshake, prescaler,
// config registers and FSM that sequence a counter_core instance.
module counter_seq_ctrl
    import counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int PRE_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_limit,
    input  logic             cmd_mode,
    input  logic [PRE_W-1:0] cmd_pre,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc_pulse,
    output logic             done,
    output logic             cmd_err
);

    localparam logic [PRE_W-1:0] PONE = {{(PRE_W-1){1'b0}}, 1'b1};

    state_e           state, state_nxt;
    logic [WIDTH-1:0] limit_q, limit_nxt;
    logic             mode_q, mode_nxt;
    logic [PRE_W-1:0] pre_q, pre_nxt;
    logic [PRE_W-1:0] pcnt, pcnt_nxt;
    logic             done_nxt, tc_nxt, err_nxt, busy_nxt, ready_nxt;
    logic             acc, tick, term;
    logic             core_en, core_clr;

    counter_core #(.WIDTH(WIDTH)) u_core (
        .clk   (clk),
        .reset (reset),
        .en    (core_en),
        .clr   (core_clr),
        .q     (count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            limit_q   <= '0;
            mode_q    <= MODE_ONESHOT;
            pre_q     <= '0;
            pcnt      <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            tc_pulse  <= 1'b0;
            done      <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            limit_q   <= limit_nxt;
            mode_q    <= mode_nxt;
            pre_q     <= pre_nxt;
            pcnt      <= pcnt_nxt;
            cmd_ready <= ready_nxt;
            busy      <= busy_nxt;
            tc_pulse  <= tc_nxt;
            done      <= done_nxt;
            cmd_err   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        limit_nxt = limit_q;
        mode_nxt  = mode_q;
        pre_nxt   = pre_q;
        pcnt_nxt  = pcnt;
        done_nxt  = done;
        tc_nxt    = 1'b0;
        err_nxt   = 1'b0;
        core_en   = 1'b0;
        core_clr  = 1'b0;

        acc       = cmd_valid & cmd_ready;
        tick      = (state == ST_RUN) && (pcnt == pre_q);
        term      = (count == limit_q);
        ready_nxt = ~acc;

        // An accepted command owns the edge; a coincident tick is dropped.
        if (acc) begin
            case (cmd_op)
                OP_LOAD: begin
                    if (state == ST_RUN) begin
                        err_nxt = 1'b1;
                    end else begin
                        limit_nxt = cmd_limit;
                        mode_nxt  = cmd_mode;
                        pre_nxt   = cmd_pre;
                        core_clr  = 1'b1;
                        pcnt_nxt  = '0;
                        done_nxt  = 1'b0;
                        state_nxt = ST_IDLE;
                    end
                end
                OP_START: begin
                    if (state == ST_RUN) begin
                        err_nxt = 1'b1;
                    end else begin
                        state_nxt = ST_RUN;
                        if (state == ST_IDLE && done) begin
                            core_clr = 1'b1;
                            pcnt_nxt = '0;
                            done_nxt = 1'b0;
                        end
                    end
                end
                OP_STOP: begin
                    if (state == ST_RUN) state_nxt = ST_PAUSE;
                end
                default: begin
                    core_clr  = 1'b1;
                    pcnt_nxt  = '0;
                    done_nxt  = 1'b0;
                    state_nxt = ST_IDLE;
                end
            endcase
        end else if (state == ST_RUN) begin
            if (tick) begin
                pcnt_nxt = '0;
                if (term) begin
                    tc_nxt = 1'b1;
                    if (mode_q == MODE_PERIODIC) begin
                        core_clr = 1'b1;
                    end else begin
                        done_nxt  = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    core_en = 1'b1;
                end
            end else begin
                pcnt_nxt = pcnt + PONE;
            end
        end

        busy_nxt = (state_nxt == ST_RUN);
    end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for counter_seq_ctrl: a per-cycle vector table plus
// hand-written sequences for reset, pause/resume and rejected commands.
module tb_counter_seq_ctrl;
    import counter_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_limit;
    logic       cmd_mode;
    logic [3:0] cmd_pre;
    logic [3:0] count;
    logic       busy, tc_pulse, done, cmd_err;

    int n_tests = 0;
    int n_fail  = 0;

    counter_seq_ctrl #(.WIDTH(4), .PRE_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_limit (cmd_limit),
        .cmd_mode  (cmd_mode),
        .cmd_pre   (cmd_pre),
        .count     (count),
        .busy      (busy),
        .tc_pulse  (tc_pulse),
        .done      (done),
        .cmd_err   (cmd_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [1:0] op;
        logic [3:0] lim;
        logic       md;
        logic [3:0] pre;
        logic [8:0] exp;   // {count, ready, busy, tc, done, err}
    } vec_t;

    vec_t vt[42];

    function automatic vec_t mk(logic v, logic [1:0] op, logic [3:0] lim, logic md,
                                logic [3:0] pre, logic [3:0] c, logic r, logic b,
                                logic t, logic d, logic e);
        vec_t x;
        x.v = v; x.op = op; x.lim = lim; x.md = md; x.pre = pre;
        x.exp = {c, r, b, t, d, e};
        return x;
    endfunction

    function automatic logic [8:0] outs();
        return {count, cmd_ready, busy, tc_pulse, done, cmd_err};
    endfunction

    task automatic chk(string name, logic [8:0] act, logic [8:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, want %b", name, act, exp);
        end
    endtask

    // drive on the falling edge, sample 1 time unit after the rising edge
    task automatic cyc(logic v, logic [1:0] op, logic [3:0] lim, logic md, logic [3:0] pre);
        @(negedge clk);
        cmd_valid = v; cmd_op = op; cmd_limit = lim; cmd_mode = md; cmd_pre = pre;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, OP_LOAD, 4'd0, 1'b0, 4'd0);
    endtask

    initial begin
        int k;
        bit seen;
        // periodic limit=3 pre=0, then CLEAR
        vt[0]  = mk(1, OP_LOAD, 3, 1, 0,  0, 0, 0, 0, 0, 0);
        vt[1]  = mk(0, OP_LOAD, 0, 0, 0,  0, 1, 0, 0, 0, 0);
        vt[2]  = mk(1, OP_START,0, 0, 0,  0, 0, 1, 0, 0, 0);
        vt[3]  = mk(0, OP_LOAD, 0, 0, 0,  1, 1, 1, 0, 0, 0);
        vt[4]  = mk(0, OP_LOAD, 0, 0, 0,  2, 1, 1, 0, 0, 0);
        vt[5]  = mk(0, OP_LOAD, 0, 0, 0,  3, 1, 1, 0, 0, 0);
        vt[6]  = mk(0, OP_LOAD, 0, 0, 0,  0, 1, 1, 1, 0, 0);
        vt[7]  = mk(0, OP_LOAD, 0, 0, 0,  1, 1, 1, 0, 0, 0);
        vt[8]  = mk(0, OP_LOAD, 0, 0, 0,  2, 1, 1, 0, 0, 0);
        vt[9]  = mk(0, OP_LOAD, 0, 0, 0,  3, 1, 1, 0, 0, 0);
        vt[10] = mk(0, OP_LOAD, 0, 0, 0,  0, 1, 1, 1, 0, 0);
        vt[11] = mk(1, OP_CLEAR,0, 0, 0,  0, 0, 0, 0, 0, 0);
        vt[12] = mk(0, OP_LOAD, 0, 0, 0,  0, 1, 0, 0, 0, 0);
        // one-shot limit=2 pre=2, then restart from done
        vt[13] = mk(1, OP_LOAD, 2, 0, 2,  0, 0, 0, 0, 0, 0);
        vt[14] = mk(0, OP_LOAD, 0, 0, 0,  0, 1, 0, 0, 0, 0);
        vt[15] = mk(1, OP_START,0, 0, 0,  0, 0, 1, 0, 0, 0);
        vt[16] = mk(0, OP_LOAD, 0, 0, 0,  0, 1, 1, 0, 0, 0);
        vt[17] = mk(0, OP_LOAD, 0, 0, 0,  0, 1, 1, 0, 0, 0);
        vt[18] = mk(0, OP_LOAD, 0, 0, 0,  1, 1, 1, 0, 0, 0);
        vt[19] = mk(0, OP_LOAD, 0, 0, 0,  1, 1, 1, 0, 0, 0);
        vt[20] = mk(0, OP_LOAD, 0, 0, 0,  1, 1, 1, 0, 0, 0);
        vt[21] = mk(0, OP_LOAD, 0, 0, 0,  2, 1, 1, 0, 0, 0);
        vt[22] = mk(0, OP_LOAD, 0, 0, 0,  2, 1, 1, 0, 0, 0);
        vt[23] = mk(0, OP_LOAD, 0, 0, 0,  2, 1, 1, 0, 0, 0);
        vt[24] = mk(0, OP_LOAD, 0, 0, 0,  2, 1, 0, 1, 1, 0);
        vt[25] = mk(0, OP_LOAD, 0, 0, 0,  2, 1, 0, 0, 1, 0);
        vt[26] = mk(1, OP_START,0, 0, 0,  0, 0, 1, 0, 0, 0);
        vt[27] = mk(0, OP_LOAD, 0, 0, 0,  0, 1, 1, 0, 0, 0);
        vt[28] = mk(1, OP_CLEAR,0, 0, 0,  0, 0, 0, 0, 0, 0);
        vt[29] = mk(0, OP_LOAD, 0, 0, 0,  0, 1, 0, 0, 0, 0);
        // periodic limit=1: CLEAR lands on the terminal-tick edge
        vt[30] = mk(1, OP_LOAD, 1, 1, 0,  0, 0, 0, 0, 0, 0);
        vt[31] = mk(0, OP_LOAD, 0, 0, 0,  0, 1, 0, 0, 0, 0);
        vt[32] = mk(1, OP_START,0, 0, 0,  0, 0, 1, 0, 0, 0);
        vt[33] = mk(0, OP_LOAD, 0, 0, 0,  1, 1, 1, 0, 0, 0);
        vt[34] = mk(1, OP_CLEAR,0, 0, 0,  0, 0, 0, 0, 0, 0);
        vt[35] = mk(0, OP_LOAD, 0, 0, 0,  0, 1, 0, 0, 0, 0);
        // START held valid: accepted every 2nd cycle, the second one rejected
        vt[36] = mk(1, OP_START,0, 0, 0,  0, 0, 1, 0, 0, 0);
        vt[37] = mk(1, OP_START,0, 0, 0,  1, 1, 1, 0, 0, 0);
        vt[38] = mk(1, OP_START,0, 0, 0,  1, 0, 1, 0, 0, 1);
        vt[39] = mk(1, OP_START,0, 0, 0,  0, 1, 1, 1, 0, 0);
        vt[40] = mk(1, OP_CLEAR,0, 0, 0,  0, 0, 0, 0, 0, 0);
        vt[41] = mk(0, OP_LOAD, 0, 0, 0,  0, 1, 0, 0, 0, 0);

        reset = 1'b1; cmd_valid = 1'b0; cmd_op = OP_LOAD;
        cmd_limit = '0; cmd_mode = 1'b0; cmd_pre = '0;
        #1;
        chk("reset_state", outs(), 9'b0000_1_0_0_0_0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 42; i++) begin
            cyc(vt[i].v, vt[i].op, vt[i].lim, vt[i].md, vt[i].pre);
            chk($sformatf("vec%0d", i), outs(), vt[i].exp);
        end

        // asynchronous reset while running at count=2
        cyc(1, OP_LOAD, 5, 1, 0);
        idle();
        cyc(1, OP_START, 0, 0, 0);
        idle();
        idle();
        chk("run_cnt2", outs(), {4'd2, 1'b1, 1'b1, 3'b000});
        #2 reset = 1'b1;
        #1 chk("reset_midrun", outs(), 9'b0000_1_0_0_0_0);
        @(negedge clk);
        reset = 1'b0;

        // pause/resume and a LOAD rejected while running
        cyc(1, OP_LOAD, 5, 0, 0);
        idle();
        cyc(1, OP_START, 0, 0, 0);
        idle(); idle(); idle();
        chk("pre_stop", outs(), {4'd3, 1'b1, 1'b1, 3'b000});
        cyc(1, OP_STOP, 0, 0, 0);
        chk("stop", outs(), {4'd3, 1'b0, 1'b0, 3'b000});
        for (int i = 0; i < 10; i++) begin
            idle();
            chk($sformatf("paused%0d", i), outs(), {4'd3, 1'b1, 1'b0, 3'b000});
        end
        cyc(1, OP_START, 0, 0, 0);
        chk("resume", outs(), {4'd3, 1'b0, 1'b1, 3'b000});
        idle();
        chk("resume_inc", outs(), {4'd4, 1'b1, 1'b1, 3'b000});
        cyc(1, OP_LOAD, 1, 1, 0);
        chk("load_in_run_err", {busy, cmd_err, cmd_ready}, 3'b110);
        idle();
        chk("err_one_cycle", {busy, cmd_err}, 2'b10);
        k = 0; seen = 1'b0;
        while (!done && k < 20) begin
            idle();
            k++;
            if (done) seen = tc_pulse;
        end
        chk("oneshot_done", {3'b0, done, seen, busy, count[2:0]}, {3'b0, 1'b1, 1'b1, 1'b0, 3'd5});
        chk("oneshot_limit_kept", {5'b0, count}, {5'b0, 4'd5});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
